// File: rtl/cv32e40p_lce_controller_if.sv
// Bus bundle between the LCE controller and its environment (core event
// logic, software kick path, detector bank and interrupt sink).
interface cv32e40p_lce_controller_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0] arm_i;
  logic [NUM_CH-1:0] disarm_i;
  logic              event_valid_i;
  logic [CHW-1:0]    event_ch_i;
  logic              kick_valid_i;
  logic [CHW-1:0]    kick_ch_i;
  logic [NUM_CH-1:0] det_alarm_i;
  logic [NUM_CH-1:0] det_init_o;
  logic [NUM_CH-1:0] det_decrement_o;
  logic [NUM_CH-1:0] armed_o;
  logic [NUM_CH-1:0] pending_o;
  logic              irq_o;
  logic [CHW-1:0]    irq_ch_o;
  logic              irq_ack_i;
  logic              fatal_o;

  // Controller side
  modport slave (
    input  arm_i, disarm_i, event_valid_i, event_ch_i, kick_valid_i, kick_ch_i,
    input  det_alarm_i, irq_ack_i,
    output det_init_o, det_decrement_o, armed_o, pending_o, irq_o, irq_ch_o, fatal_o
  );

  // Environment side
  modport master (
    output arm_i, disarm_i, event_valid_i, event_ch_i, kick_valid_i, kick_ch_i,
    output det_alarm_i, irq_ack_i,
    input  det_init_o, det_decrement_o, armed_o, pending_o, irq_o, irq_ch_o, fatal_o
  );
endinterface

// File: rtl/cv32e40p_lce_controller.sv
// Sequencing/escalation controller for a bank of LCE countdown detectors.
// Per-channel DISARMED/ARMED/FIRED FSMs route events and kicks into registered
// decrement/init pulses; FIRED channels are served round-robin on one irq line
// with ack handshake and post-ack holdoff.
// Optional: define LCE_CTRL_ACK_TIMEOUT_EN for a sticky fatal_o on ack timeout.
module cv32e40p_lce_controller #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned HOLDOFF_CYCLES = 8,
  parameter int unsigned ACK_TIMEOUT    = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  cv32e40p_lce_controller_if.slave   bus
);
  localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned HW  = $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic [1:0] {CH_DISARMED = 2'd0, CH_ARMED = 2'd1, CH_FIRED = 2'd2} ch_state_e;
  typedef enum logic [1:0] {ESC_IDLE = 2'd0, ESC_IRQ = 2'd1, ESC_HOLDOFF = 2'd2} esc_state_e;

  // Elaboration-time parameter sanity
  if (NUM_CH < 1 || NUM_CH > 16 || HOLDOFF_CYCLES < 1 || ACK_TIMEOUT < 1) begin : g_bad_cfg
    $error("cv32e40p_lce_controller: illegal parameter combination");
  end

  ch_state_e         ch_q [NUM_CH];
  ch_state_e         ch_d [NUM_CH];
  esc_state_e        esc_q, esc_d;
  logic [NUM_CH-1:0] init_q, init_d;
  logic [NUM_CH-1:0] dec_q, dec_d;
  logic [CHW-1:0]    ptr_q, ptr_d;
  logic [CHW-1:0]    sel_q, sel_d;
  logic              irq_q, irq_d;
  logic [HW-1:0]     hold_q, hold_d;

  logic [NUM_CH-1:0] fired_c, armed_c, pend_c;
  logic              found_c;
  logic [CHW-1:0]    found_ch_c, rr_idx_c, sel_next_c;
  logic              release_c;

  // Per-channel status decode; a channel being disarmed is not eligible for selection
  always_comb begin
    fired_c = '0;
    armed_c = '0;
    pend_c  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      pend_c[c]  = (ch_q[c] == CH_FIRED);
      armed_c[c] = (ch_q[c] != CH_DISARMED);
      fired_c[c] = (ch_q[c] == CH_FIRED) && !bus.disarm_i[c];
    end
  end

  // Round-robin pick: first eligible FIRED channel at or after the pointer
  always_comb begin
    found_c    = 1'b0;
    found_ch_c = '0;
    rr_idx_c   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      rr_idx_c = CHW'((32'(ptr_q) + i) % NUM_CH);
      if (!found_c && fired_c[rr_idx_c]) begin
        found_c    = 1'b1;
        found_ch_c = rr_idx_c;
      end
    end
  end

  assign sel_next_c = (32'(sel_q) == NUM_CH - 1) ? '0 : sel_q + CHW'(1);

  // Escalation and channel next-state; disarm beats every other request
  always_comb begin
    ch_d      = ch_q;
    init_d    = '0;
    dec_d     = '0;
    esc_d     = esc_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    irq_d     = irq_q;
    hold_d    = hold_q;
    release_c = 1'b0;

    case (esc_q)
      ESC_IDLE: begin
        if (found_c) begin
          sel_d = found_ch_c;
          irq_d = 1'b1;
          esc_d = ESC_IRQ;
        end
      end
      ESC_IRQ: begin
        if (bus.disarm_i[sel_q]) begin
          irq_d  = 1'b0;
          ptr_d  = sel_next_c;
          hold_d = HW'(HOLDOFF_CYCLES);
          esc_d  = ESC_HOLDOFF;
        end else if (bus.irq_ack_i) begin
          irq_d     = 1'b0;
          release_c = 1'b1;
          ptr_d     = sel_next_c;
          hold_d    = HW'(HOLDOFF_CYCLES);
          esc_d     = ESC_HOLDOFF;
        end
      end
      ESC_HOLDOFF: begin
        hold_d = hold_q - HW'(1);
        if (hold_q <= HW'(1)) begin
          hold_d = '0;
          esc_d  = ESC_IDLE;
        end
      end
      default: esc_d = ESC_IDLE;
    endcase

    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (bus.disarm_i[c]) begin
        ch_d[c] = CH_DISARMED;
      end else begin
        case (ch_q[c])
          CH_DISARMED: begin
            if (bus.arm_i[c]) begin
              ch_d[c]   = CH_ARMED;
              init_d[c] = 1'b1;
            end
          end
          CH_ARMED: begin
            if (bus.kick_valid_i && bus.kick_ch_i == CHW'(c)) begin
              init_d[c] = 1'b1;
            end else if (bus.event_valid_i && bus.event_ch_i == CHW'(c)) begin
              dec_d[c] = 1'b1;
            end
            if (bus.det_alarm_i[c]) begin
              ch_d[c] = CH_FIRED;
            end
          end
          CH_FIRED: begin
            if (release_c && sel_q == CHW'(c)) begin
              ch_d[c]   = CH_ARMED;
              init_d[c] = 1'b1;
            end
          end
          default: ch_d[c] = CH_DISARMED;
        endcase
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        ch_q[c] <= CH_DISARMED;
      end
      esc_q  <= ESC_IDLE;
      init_q <= '0;
      dec_q  <= '0;
      ptr_q  <= '0;
      sel_q  <= '0;
      irq_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      ch_q   <= ch_d;
      esc_q  <= esc_d;
      init_q <= init_d;
      dec_q  <= dec_d;
      ptr_q  <= ptr_d;
      sel_q  <= sel_d;
      irq_q  <= irq_d;
      hold_q <= hold_d;
    end
  end

  assign bus.det_init_o      = init_q;
  assign bus.det_decrement_o = dec_q;
  assign bus.armed_o         = armed_c;
  assign bus.pending_o       = pend_c;
  assign bus.irq_o           = irq_q;
  assign bus.irq_ch_o        = sel_q;

`ifdef LCE_CTRL_ACK_TIMEOUT_EN
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  logic [TW-1:0] to_q, to_d;
  logic          fatal_q, fatal_d;

  // Count unacked IRQ cycles; saturate and latch fatal at the limit
  always_comb begin
    to_d    = to_q;
    fatal_d = fatal_q;
    if (esc_q != ESC_IRQ) begin
      to_d = '0;
    end else if (!bus.irq_ack_i && to_q != TW'(ACK_TIMEOUT)) begin
      to_d = to_q + TW'(1);
    end
    if (to_d == TW'(ACK_TIMEOUT)) begin
      fatal_d = 1'b1;
    end
  end

  // Timeout counter and sticky fatal flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_q    <= '0;
      fatal_q <= 1'b0;
    end else begin
      to_q    <= to_d;
      fatal_q <= fatal_d;
    end
  end

  assign bus.fatal_o = fatal_q;
`else
  assign bus.fatal_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40p_lce_controller.sv
// Directed bench for cv32e40p_lce_controller: vector table for routing and
// single-fault flow, hand sequences for round-robin/holdoff, disarm of the
// reported channel, and the ack-timeout flag.
module tb_cv32e40p_lce_controller;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CHW    = 2;
  localparam int unsigned NV     = 20;
`ifdef LCE_CTRL_ACK_TIMEOUT_EN
  localparam logic EXP_FATAL = 1'b1;
`else
  localparam logic EXP_FATAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cv32e40p_lce_controller_if #(.NUM_CH(NUM_CH)) bus ();

  cv32e40p_lce_controller #(
    .NUM_CH(NUM_CH), .HOLDOFF_CYCLES(8), .ACK_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic [3:0]     arm;
    logic [3:0]     disarm;
    logic           ev_v;
    logic [CHW-1:0] ev_ch;
    logic           k_v;
    logic [CHW-1:0] k_ch;
    logic [3:0]     alarm;
    logic           ack;
    logic [3:0]     e_init;
    logic [3:0]     e_dec;
    logic [3:0]     e_armed;
    logic [3:0]     e_pend;
    logic           e_irq;
    logic [CHW-1:0] e_ch;
  } vec_t;

  vec_t vecs [NV];
  int   errors = 0;
  int   checks = 0;
  int   n;
  logic seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.arm_i = '0; bus.disarm_i = '0; bus.event_valid_i = 1'b0; bus.event_ch_i = '0;
    bus.kick_valid_i = 1'b0; bus.kick_ch_i = '0; bus.det_alarm_i = '0; bus.irq_ack_i = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_irq(output int cnt);
    cnt = 0;
    while (bus.irq_o !== 1'b1 && cnt < 30) begin
      step();
      cnt++;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //         arm      disarm   ev ch    kick ch  alarm    ack | init     dec      armed    pend     irq ch
    vecs[0]  = '{4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd0};
    vecs[1]  = '{4'b0000, 4'b0000, 1'b1, 2'd2, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd0};
    vecs[2]  = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd0};
    vecs[3]  = '{4'b0000, 4'b0000, 1'b1, 2'd2, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd0};
    vecs[4]  = '{4'b0000, 4'b0000, 1'b1, 2'd2, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd0};
    vecs[5]  = '{4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd0};
    vecs[6]  = '{4'b0000, 4'b0000, 1'b1, 2'd2, 1'b1, 2'd2, 4'b0000, 1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd0};
    vecs[7]  = '{4'b0000, 4'b0000, 1'b1, 2'd1, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd0};
    vecs[8]  = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd0};
    vecs[9]  = '{4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd0};
    vecs[10] = '{4'b0010, 4'b0010, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd0};
    vecs[11] = '{4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0110, 4'b0000, 1'b0, 2'd0};
    vecs[12] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0110, 4'b0010, 1'b0, 2'd0};
    vecs[13] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0110, 4'b0010, 1'b1, 2'd1};
    vecs[14] = '{4'b0000, 4'b0000, 1'b1, 2'd1, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0110, 4'b0010, 1'b1, 2'd1};
    vecs[15] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0110, 4'b0010, 1'b1, 2'd1};
    vecs[16] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0010, 4'b0000, 4'b0110, 4'b0000, 1'b0, 2'd0};
    vecs[17] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0110, 4'b0000, 1'b0, 2'd0};
    vecs[18] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0110, 4'b0000, 1'b0, 2'd0};
    vecs[19] = '{4'b0000, 4'b0000, 1'b1, 2'd2, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 4'b0100, 4'b0110, 4'b0000, 1'b0, 2'd0};

    // Reset with noisy inputs: every output must be 0
    clear_inputs();
    bus.arm_i = 4'hF; bus.det_alarm_i = 4'hF; bus.kick_valid_i = 1'b1; bus.irq_ack_i = 1'b1;
    rst_n = 1'b0;
    step();
    step();
    chk("rst_init", bus.det_init_o, 0);
    chk("rst_dec", bus.det_decrement_o, 0);
    chk("rst_armed", bus.armed_o, 0);
    chk("rst_pend", bus.pending_o, 0);
    chk("rst_irq", bus.irq_o, 0);
    chk("rst_irq_ch", bus.irq_ch_o, 0);
    chk("rst_fatal", bus.fatal_o, 0);
    clear_inputs();
    rst_n = 1'b1;

    // Vector table: routing, priority, single fault round trip
    for (int i = 0; i < NV; i++) begin
      bus.arm_i = vecs[i].arm;           bus.disarm_i = vecs[i].disarm;
      bus.event_valid_i = vecs[i].ev_v;  bus.event_ch_i = vecs[i].ev_ch;
      bus.kick_valid_i = vecs[i].k_v;    bus.kick_ch_i = vecs[i].k_ch;
      bus.det_alarm_i = vecs[i].alarm;   bus.irq_ack_i = vecs[i].ack;
      step();
      chk($sformatf("v%0d_init", i), bus.det_init_o, vecs[i].e_init);
      chk($sformatf("v%0d_dec", i), bus.det_decrement_o, vecs[i].e_dec);
      chk($sformatf("v%0d_armed", i), bus.armed_o, vecs[i].e_armed);
      chk($sformatf("v%0d_pend", i), bus.pending_o, vecs[i].e_pend);
      chk($sformatf("v%0d_irq", i), bus.irq_o, vecs[i].e_irq);
      if (vecs[i].e_irq) chk($sformatf("v%0d_irq_ch", i), bus.irq_ch_o, vecs[i].e_ch);
    end
    clear_inputs();

    // Round robin and holdoff: ch0+ch3 together, ch0 re-fires, ch1 fires on an ack
    do_reset();
    bus.arm_i = 4'b1011;
    step();
    chk("rr_arm_init", bus.det_init_o, 4'b1011);
    bus.arm_i = '0; bus.det_alarm_i = 4'b1001;
    step();
    chk("rr_pend0", bus.pending_o, 4'b1001);
    chk("rr_irq_lo", bus.irq_o, 0);
    bus.det_alarm_i = '0;
    step();
    chk("rr_irq_first", bus.irq_o, 1);
    chk("rr_ch_first", bus.irq_ch_o, 0);
    step();
    step();
    chk("rr_irq_held", bus.irq_o, 1);
    chk("rr_ch_held", bus.irq_ch_o, 0);
    bus.irq_ack_i = 1'b1;
    step();
    bus.irq_ack_i = 1'b0;
    chk("rr_ack0_irq", bus.irq_o, 0);
    chk("rr_ack0_init", bus.det_init_o, 4'b0001);
    chk("rr_ack0_pend", bus.pending_o, 4'b1000);
    bus.det_alarm_i = 4'b0001;
    step();
    bus.det_alarm_i = '0;
    chk("rr_refire_pend", bus.pending_o, 4'b1001);
    chk("rr_holdoff_irq", bus.irq_o, 0);
    wait_irq(n);
    chk("rr_gap1", n, 8);
    chk("rr_ch_second", bus.irq_ch_o, 3);
    bus.irq_ack_i = 1'b1; bus.det_alarm_i = 4'b0010;
    step();
    bus.irq_ack_i = 1'b0; bus.det_alarm_i = '0;
    chk("rr_ack3_irq", bus.irq_o, 0);
    chk("rr_ack3_init", bus.det_init_o, 4'b1000);
    chk("rr_ack3_pend", bus.pending_o, 4'b0011);
    wait_irq(n);
    chk("rr_gap2", n, 9);
    chk("rr_ch_wrap", bus.irq_ch_o, 0);
    bus.irq_ack_i = 1'b1;
    step();
    bus.irq_ack_i = 1'b0;
    chk("rr_ack0b_init", bus.det_init_o, 4'b0001);
    chk("rr_ack0b_pend", bus.pending_o, 4'b0010);
    wait_irq(n);
    chk("rr_gap3", n, 9);
    chk("rr_ch_last", bus.irq_ch_o, 1);

    // Disarm the channel being reported
    do_reset();
    bus.arm_i = 4'b0010;
    step();
    bus.arm_i = '0; bus.det_alarm_i = 4'b0010;
    step();
    bus.det_alarm_i = '0;
    step();
    chk("dis_irq_up", bus.irq_o, 1);
    chk("dis_irq_ch", bus.irq_ch_o, 1);
    bus.disarm_i = 4'b0010; bus.irq_ack_i = 1'b1;
    step();
    bus.disarm_i = '0; bus.irq_ack_i = 1'b0;
    chk("dis_irq_drop", bus.irq_o, 0);
    chk("dis_armed", bus.armed_o, 0);
    chk("dis_init", bus.det_init_o, 0);
    chk("dis_pend", bus.pending_o, 0);
    bus.det_alarm_i = 4'b0010; bus.event_valid_i = 1'b1; bus.event_ch_i = 2'd1;
    step();
    clear_inputs();
    chk("dis_alarm_pend", bus.pending_o, 0);
    chk("dis_ev_dec", bus.det_decrement_o, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.irq_o !== 1'b0 || bus.det_init_o !== 4'b0000) seen = 1'b1;
    end
    chk("dis_quiet", seen, 0);

    // Ack timeout, sticky fatal, reset in the middle of an IRQ
    do_reset();
    bus.arm_i = 4'b0001;
    step();
    bus.arm_i = '0; bus.det_alarm_i = 4'b0001;
    step();
    bus.det_alarm_i = '0;
    step();
    chk("to_irq_up", bus.irq_o, 1);
    repeat (15) step();
    chk("to_fatal_early", bus.fatal_o, 0);
    step();
    chk("to_fatal_set", bus.fatal_o, EXP_FATAL);
    chk("to_irq_still", bus.irq_o, 1);
    bus.irq_ack_i = 1'b1;
    step();
    bus.irq_ack_i = 1'b0;
    chk("to_ack_irq", bus.irq_o, 0);
    chk("to_fatal_sticky", bus.fatal_o, EXP_FATAL);
    bus.det_alarm_i = 4'b0001;
    step();
    bus.det_alarm_i = '0;
    wait_irq(n);
    chk("to_refire_gap", n, 8);
    rst_n = 1'b0; bus.irq_ack_i = 1'b1;
    step();
    chk("mid_rst_irq", bus.irq_o, 0);
    chk("mid_rst_init", bus.det_init_o, 0);
    chk("mid_rst_armed", bus.armed_o, 0);
    chk("mid_rst_fatal", bus.fatal_o, 0);
    rst_n = 1'b1; bus.irq_ack_i = 1'b0;
    step();
    chk("post_rst_init", bus.det_init_o, 0);
    chk("post_rst_pend", bus.pending_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
